// File: rtl/axi_buffer_flex.sv
// rtl/axi_buffer_flex.sv - parametrised channel FIFO with optional fall-through, flush and level flags
module axi_buffer_flex #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BUFFER_DEPTH  = 4,
  parameter int unsigned FALL_THROUGH  = 0,
  parameter int unsigned AFULL_THRESH  = BUFFER_DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter int unsigned PTR_WIDTH     = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1,
  parameter int unsigned CNT_WIDTH     = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(BUFFER_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_ready;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_wr;
  logic                  w_rd;

  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_empty = (r_count == '0);
    // ready depends only on stored level, never on ready_i
    w_ready = !w_full && !flush_i;
    if (FALL_THROUGH != 0) begin
      // bypass path is gated by reset so nothing leaks out while held in reset
      w_valid = (!w_empty || valid_i) && !flush_i && rst_ni;
      w_data  = w_empty ? (rst_ni ? data_i : '0) : r_mem[r_rd_ptr];
    end else begin
      w_valid = !w_empty && !flush_i;
      w_data  = r_mem[r_rd_ptr];
    end
    w_push   = valid_i && w_ready;
    w_pop    = w_valid && ready_i;
    w_bypass = (FALL_THROUGH != 0) && w_empty && w_push && w_pop;
    w_wr     = w_push && !w_bypass;
    w_rd     = w_pop && !w_bypass;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ready_o        = w_ready;
  assign valid_o        = w_valid;
  assign data_o         = w_data;
  assign count_o        = r_count;
  assign almost_full_o  = (32'(r_count) >= AFULL_THRESH);
  assign almost_empty_o = (32'(r_count) <= AEMPTY_THRESH);

endmodule

// File: doc/axi_buffer_flex.md
Name: axi_buffer_flex

Overview:
- Parametrised successor FIFO for AXI ar/aw/w/r/b channel buffering in the interconnect and slices.
- Adds optional fall-through (zero-latency) mode, a synchronous flush, a fill-level output and programmable almost-full/almost-empty flags.
- Valid/ready handshakes on both sides; one push and one pop per cycle maximum.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- BUFFER_DEPTH, 4, number of storage entries (>=1); need not be a power of two.
- FALL_THROUGH, 0, 1 = empty FIFO forwards data_i to data_o in the same cycle; 0 = registered, minimum latency 1 cycle.
- AFULL_THRESH, BUFFER_DEPTH-1, almost_full_o asserts when count >= this value.
- AEMPTY_THRESH, 1, almost_empty_o asserts when count <= this value.
- PTR_WIDTH, max(1,$clog2(BUFFER_DEPTH)), derived; do not override.
- CNT_WIDTH, $clog2(BUFFER_DEPTH+1), derived; do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset: asynchronous, active-low.
- flush_i  in  1  synchronous clear of all stored entries.
- valid_i  in  1  upstream valid.
- data_i  in  DATA_WIDTH  upstream payload.
- ready_o  out  1  upstream ready.
- valid_o  out  1  downstream valid.
- data_o  out  DATA_WIDTH  downstream payload.
- ready_i  in  1  downstream ready.
- count_o  out  CNT_WIDTH  number of stored entries (0..BUFFER_DEPTH).
- almost_full_o  out  1  count_o >= AFULL_THRESH.
- almost_empty_o  out  1  count_o <= AEMPTY_THRESH.

Behaviour:
- Reset (rst_ni=0, async): count=0, rd/wr pointers=0, all storage words=0.
  - Outputs during reset: valid_o=0, ready_o=1, data_o=0, count_o=0, almost_empty_o=1, almost_full_o=(AFULL_THRESH==0).
- full = (count==BUFFER_DEPTH); empty = (count==0).
- ready_o = !full && !flush_i. No combinational path from ready_i to ready_o: the FIFO does not accept when full, even if a pop occurs in the same cycle.
- push = valid_i && ready_o. pop = valid_o && ready_i.
- FALL_THROUGH=0:
  - valid_o = !empty && !flush_i; data_o = mem[rd_ptr].
  - A push writes mem[wr_ptr] and is visible at the output the next cycle.
- FALL_THROUGH=1:
  - valid_o = (!empty || valid_i) && !flush_i; data_o = empty ? data_i : mem[rd_ptr].
  - When empty and push and pop coincide, the word bypasses storage: no write, pointers and count unchanged.
- Storage write and wr_ptr advance on push, except in the bypass case above.
- rd_ptr advances on pop, except in the bypass case above.
- Both pointers wrap from BUFFER_DEPTH-1 to 0, including for non-power-of-two depths.
- Count update:
  - +1 on stored push without pop.
  - -1 on pop without stored push.
  - Unchanged on push+pop (both stored, or bypass) and when idle.
- Count never exceeds BUFFER_DEPTH and never underflows.
- flush_i=1: that cycle ready_o=0 and valid_o=0, so no handshake completes. Next edge: count=0, rd_ptr=wr_ptr=0. Storage contents are not cleared.
- Data order is strictly FIFO. data_o is stable while valid_o=1 and ready_i=0, as long as flush_i=0.
- Flags are combinational from count_o only; in fall-through mode they exclude any bypassed word.
- Reset asserted mid-transfer discards all contents immediately; no handshake completes while rst_ni=0.

Test Plan:
- Reset, FALL_THROUGH=0, DEPTH=4: push A,B,C,D with ready_i=0 -> count_o 1,2,3,4; ready_o=0 after D; almost_full_o=1 at count 3. Raise ready_i -> A,B,C,D out on consecutive cycles, count_o back to 0.
- FALL_THROUGH=1, empty, valid_i=1, data_i=0x55, ready_i=1 -> same-cycle valid_o=1, data_o=0x55; count_o stays 0.
- Full DEPTH=4 with valid_i=1 and ready_i=1 -> one pop per cycle; push accepted only once count_o=3 (no accept while full); order preserved.
- DEPTH=3 (non-power-of-two): 10 interleaved push/pop with random stalls -> pointers wrap 2->0; output matches a scoreboard; count_o never exceeds 3.
- Count 2, assert flush_i for 1 cycle while valid_i=1 -> valid_o=0 and ready_o=0 that cycle; next cycle count_o=0, almost_empty_o=1, the flushed and offered words are never output.
- Assert rst_ni=0 asynchronously at count 3 between edges -> valid_o=0 and count_o=0 immediately; after release, the first push is output correctly.
